axicb_reg_slice: RTL and testbench

//  Configurable AXI-style valid/ready register slice for crossbar channels (AW/W/B/AR/R).

---
 rtl/axicb_reg_slice_if.sv | 12 +
 rtl/axicb_reg_slice.sv | 185 ++++++++++++++++++
 tb/tb_axicb_reg_slice.sv | 294 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/axicb_reg_slice_if.sv
// Valid/ready channel bundle used on both sides of the crossbar register slice.
// The master side drives valid and data, and the slave side answers with ready.
interface axicb_reg_slice_if #(
   parameter int DATA_BUS_W = 8
) ();
   logic                  valid;
   logic                  ready;
   logic [DATA_BUS_W-1:0] data;

   modport master (output valid, output data, input ready);
   modport slave  (input valid, input data, output ready);
endinterface

// File: rtl/axicb_reg_slice.sv
// Configurable valid/ready register slice for crossbar channels.
// The slice is a chain of NB_STAGES identical stages. MODE selects the stage type:
//  0 = bypass
//  1 = forward register (registers valid/data)
//  2 = skid buffer (registers ready)
//  3 = full two-entry slice (registers everything)
// aresetn clears state asynchronously. srst clears state on the clock edge where it is sampled high.
module axicb_reg_slice #(
   parameter int DATA_BUS_W = 8,
   parameter int NB_STAGES  = 1,
   parameter int MODE       = 3
) (
   input  logic              aclk,
   input  logic              aresetn,
   input  logic              srst,
   axicb_reg_slice_if.slave  i_bus,
   axicb_reg_slice_if.master o_bus,
   output logic              busy
);

   typedef enum logic [1:0] {ST_EMPTY, ST_ONE, ST_TWO} slice_state_t;

   if (MODE < 0 || MODE > 3 || NB_STAGES < 0) begin : g_bad_param
      $error("axicb_reg_slice: MODE must be 0..3 and NB_STAGES must be >= 0");
   end

   if (NB_STAGES == 0 || MODE == 0) begin : g_bypass
      // Pure wires: no state exists, so the clock and reset inputs are deliberately unused.
      logic unused_bypass;
      assign o_bus.valid   = i_bus.valid;
      assign o_bus.data    = i_bus.data;
      assign i_bus.ready   = o_bus.ready;
      assign busy          = 1'b0;
      assign unused_bypass = ^{aclk, aresetn, srst};
   end else begin : g_chain
      // Index k is the input of stage k. Index NB_STAGES is the slice output.
      logic [NB_STAGES:0]                 ch_valid;
      logic [NB_STAGES:0]                 ch_ready;
      logic [NB_STAGES:0][DATA_BUS_W-1:0] ch_data;
      logic [NB_STAGES-1:0]               stage_busy;

      assign ch_valid[0]         = i_bus.valid;
      assign ch_data[0]          = i_bus.data;
      assign i_bus.ready         = ch_ready[0];
      assign o_bus.valid         = ch_valid[NB_STAGES];
      assign o_bus.data          = ch_data[NB_STAGES];
      assign ch_ready[NB_STAGES] = o_bus.ready;
      assign busy                = |stage_busy;

      for (genvar k = 0; k < NB_STAGES; k++) begin : g_stage
         if (MODE == 1) begin : g_fwd
            logic                  v;
            logic [DATA_BUS_W-1:0] d;
            logic                  rdy;

            assign rdy           = ~v | ch_ready[k+1];
            assign ch_ready[k]   = rdy;
            assign ch_valid[k+1] = v;
            assign ch_data[k+1]  = d;
            assign stage_busy[k] = v;

            // Forward register: reloads whenever the stage is empty or its word is being taken.
            always_ff @(posedge aclk or negedge aresetn) begin
               if (!aresetn) begin
                  v <= 1'b0;
                  d <= '0;
               end else if (srst) begin
                  v <= 1'b0;
                  d <= '0;
               end else if (rdy) begin
                  v <= ch_valid[k];
                  d <= ch_data[k];
               end
            end
         end else if (MODE == 2) begin : g_bwd
            logic                  sv;
            logic [DATA_BUS_W-1:0] sd;

            assign ch_ready[k]   = ~sv;
            assign ch_valid[k+1] = ch_valid[k] | sv;
            assign ch_data[k+1]  = sv ? sd : ch_data[k];
            assign stage_busy[k] = sv;

            // Skid register: catches a word offered while downstream stalls and empties once downstream takes it.
            always_ff @(posedge aclk or negedge aresetn) begin
               if (!aresetn) begin
                  sv <= 1'b0;
                  sd <= '0;
               end else if (srst) begin
                  sv <= 1'b0;
                  sd <= '0;
               end else if (!sv && ch_valid[k] && !ch_ready[k+1]) begin
                  sv <= 1'b1;
                  sd <= ch_data[k];
               end else if (sv && ch_ready[k+1]) begin
                  sv <= 1'b0;
               end
            end
         end else begin : g_full
            slice_state_t          state;
            slice_state_t          state_nxt;
            logic [DATA_BUS_W-1:0] m;
            logic [DATA_BUS_W-1:0] s;
            logic                  take_in;
            logic                  give_out;
            logic                  load_m_in;
            logic                  load_s_in;
            logic                  load_m_s;

            assign take_in       = ch_valid[k] & (state != ST_TWO);
            assign give_out      = (state != ST_EMPTY) & ch_ready[k+1];
            assign ch_ready[k]   = (state != ST_TWO);
            assign ch_valid[k+1] = (state != ST_EMPTY);
            assign ch_data[k+1]  = m;
            assign stage_busy[k] = (state != ST_EMPTY);

            // Occupancy state register.
            always_ff @(posedge aclk or negedge aresetn) begin
               if (!aresetn) begin
                  state <= ST_EMPTY;
               end else if (srst) begin
                  state <= ST_EMPTY;
               end else begin
                  state <= state_nxt;
               end
            end

            // Next occupancy and which register loads, based on this cycle's input and output transfers.
            always_comb begin
               state_nxt = state;
               load_m_in = 1'b0;
               load_s_in = 1'b0;
               load_m_s  = 1'b0;
               case (state)
                  ST_EMPTY: begin
                     if (take_in) begin
                        state_nxt = ST_ONE;
                        load_m_in = 1'b1;
                     end
                  end
                  ST_ONE: begin
                     if (take_in && give_out) begin
                        load_m_in = 1'b1;
                     end else if (take_in) begin
                        state_nxt = ST_TWO;
                        load_s_in = 1'b1;
                     end else if (give_out) begin
                        state_nxt = ST_EMPTY;
                     end
                  end
                  ST_TWO: begin
                     if (give_out) begin
                        state_nxt = ST_ONE;
                        load_m_s  = 1'b1;
                     end
                  end
                  default: state_nxt = ST_EMPTY;
               endcase
            end

            // Payload registers.
            // m always holds the oldest word. s holds the word that arrived while m was stalled.
            always_ff @(posedge aclk or negedge aresetn) begin
               if (!aresetn) begin
                  m <= '0;
                  s <= '0;
               end else if (srst) begin
                  m <= '0;
                  s <= '0;
               end else begin
                  if (load_m_in) begin
                     m <= ch_data[k];
                  end else if (load_m_s) begin
                     m <= s;
                  end
                  if (load_s_in) begin
                     s <= ch_data[k];
                  end
               end
            end
         end
      end
   end

endmodule

// File: tb/tb_axicb_reg_slice.sv
// Directed bench for axicb_reg_slice.
// It covers bypass, forward, skid and full slices (single and three-stage), plus the sync/async clears.
module tb_axicb_reg_slice;

   logic aclk    = 1'b0;
   logic aresetn = 1'b0;
   logic srst    = 1'b0;
   logic clk_run = 1'b1;
   int   n_cmp   = 0;
   int   n_err   = 0;

   logic f1_busy, bw_busy, fw3_busy, fu3_busy, byp_busy;

   axicb_reg_slice_if #(.DATA_BUS_W(8)) f1_i (), f1_o ();
   axicb_reg_slice_if #(.DATA_BUS_W(8)) bw_i (), bw_o ();
   axicb_reg_slice_if #(.DATA_BUS_W(8)) fw3_i (), fw3_o ();
   axicb_reg_slice_if #(.DATA_BUS_W(8)) fu3_i (), fu3_o ();
   axicb_reg_slice_if #(.DATA_BUS_W(8)) byp_i (), byp_o ();

   axicb_reg_slice #(.DATA_BUS_W(8), .NB_STAGES(1), .MODE(3)) u_f1 (
      .aclk(aclk), .aresetn(aresetn), .srst(srst), .i_bus(f1_i), .o_bus(f1_o), .busy(f1_busy));
   axicb_reg_slice #(.DATA_BUS_W(8), .NB_STAGES(1), .MODE(2)) u_bw (
      .aclk(aclk), .aresetn(aresetn), .srst(srst), .i_bus(bw_i), .o_bus(bw_o), .busy(bw_busy));
   axicb_reg_slice #(.DATA_BUS_W(8), .NB_STAGES(3), .MODE(1)) u_fw3 (
      .aclk(aclk), .aresetn(aresetn), .srst(srst), .i_bus(fw3_i), .o_bus(fw3_o), .busy(fw3_busy));
   axicb_reg_slice #(.DATA_BUS_W(8), .NB_STAGES(3), .MODE(3)) u_fu3 (
      .aclk(aclk), .aresetn(aresetn), .srst(srst), .i_bus(fu3_i), .o_bus(fu3_o), .busy(fu3_busy));
   axicb_reg_slice #(.DATA_BUS_W(8), .NB_STAGES(0), .MODE(3)) u_byp (
      .aclk(aclk), .aresetn(aresetn), .srst(srst), .i_bus(byp_i), .o_bus(byp_o), .busy(byp_busy));

   // Free-running clock that can be frozen low for the async reset scenario.
   always begin
      #5;
      if (clk_run) aclk = ~aclk;
   end

   // Global time bound so a stuck run still terminates.
   initial begin
      #1000000;
      $display("[TB] FAIL watchdog: got timeout want finish");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic cyc();
      @(posedge aclk);
      #1;
   endtask

   task automatic smp();
      @(negedge aclk);
   endtask

   task automatic test_reset();
      repeat (2) @(posedge aclk);
      #1;
      n_cmp++; if (f1_o.valid !== 1'b0) begin n_err++; $display("[TB] FAIL rst_f1_ovalid: got %b want 0", f1_o.valid); end
      n_cmp++; if (f1_i.ready !== 1'b1) begin n_err++; $display("[TB] FAIL rst_f1_iready: got %b want 1", f1_i.ready); end
      n_cmp++; if (f1_busy !== 1'b0) begin n_err++; $display("[TB] FAIL rst_f1_busy: got %b want 0", f1_busy); end
      n_cmp++; if (bw_i.ready !== 1'b1) begin n_err++; $display("[TB] FAIL rst_bw_iready: got %b want 1", bw_i.ready); end
      n_cmp++; if (fw3_i.ready !== 1'b1) begin n_err++; $display("[TB] FAIL rst_fw3_iready: got %b want 1", fw3_i.ready); end
      n_cmp++; if ({fw3_o.valid, fw3_busy, fu3_o.valid, fu3_busy} !== 4'b0000) begin
         n_err++; $display("[TB] FAIL rst_chain_idle: got %b want 0000", {fw3_o.valid, fw3_busy, fu3_o.valid, fu3_busy});
      end
      aresetn = 1'b1;
      cyc();
   endtask

   task automatic test_bypass();
      byp_i.valid = 1'b1; byp_i.data = 8'h3C; byp_o.ready = 1'b0;
      #1;
      n_cmp++; if ({byp_o.valid, byp_o.data, byp_i.ready, byp_busy} !== {1'b1, 8'h3C, 1'b0, 1'b0}) begin
         n_err++; $display("[TB] FAIL bypass_stall: got %b want %b", {byp_o.valid, byp_o.data, byp_i.ready, byp_busy}, {1'b1, 8'h3C, 1'b0, 1'b0});
      end
      byp_o.ready = 1'b1; byp_i.data = 8'hC3;
      #1;
      n_cmp++; if ({byp_o.data, byp_i.ready} !== {8'hC3, 1'b1}) begin
         n_err++; $display("[TB] FAIL bypass_ready: got %h/%b want c3/1", byp_o.data, byp_i.ready);
      end
      byp_i.valid = 1'b0;
      cyc();
   endtask

   task automatic test_stream();
      f1_o.ready = 1'b1;
      for (int c = 0; c <= 16; c++) begin
         f1_i.valid = (c < 16);
         f1_i.data  = 8'(c);
         smp();
         if (c < 16) begin
            n_cmp++; if (f1_i.ready !== 1'b1) begin n_err++; $display("[TB] FAIL stream_iready c%0d: got %b want 1", c, f1_i.ready); end
         end
         if (c >= 1) begin
            n_cmp++; if ({f1_o.valid, f1_o.data} !== {1'b1, 8'(c - 1)}) begin
               n_err++; $display("[TB] FAIL stream_out c%0d: got %b/%h want 1/%h", c, f1_o.valid, f1_o.data, 8'(c - 1));
            end
         end
         cyc();
      end
      f1_i.valid = 1'b0;
      smp();
      n_cmp++; if (f1_o.valid !== 1'b0) begin n_err++; $display("[TB] FAIL stream_drain: got %b want 0", f1_o.valid); end
      cyc();
   endtask

   // Row layout: {i_valid, i_data[7:0], o_ready, exp_i_ready, exp_o_valid, exp_o_data[7:0]}
   task automatic test_backpressure();
      logic [19:0] tbl [7];
      tbl = '{ {1'b1, 8'hA1, 1'b0, 1'b1, 1'b0, 8'h00},
               {1'b1, 8'hB2, 1'b0, 1'b1, 1'b1, 8'hA1},
               {1'b1, 8'hC3, 1'b0, 1'b0, 1'b1, 8'hA1},
               {1'b1, 8'hC3, 1'b1, 1'b0, 1'b1, 8'hA1},
               {1'b1, 8'hC3, 1'b1, 1'b1, 1'b1, 8'hB2},
               {1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 8'hC3},
               {1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 8'h00} };
      for (int c = 0; c < 7; c++) begin
         f1_i.valid = tbl[c][19]; f1_i.data = tbl[c][18:11]; f1_o.ready = tbl[c][10];
         smp();
         n_cmp++; if ({f1_i.ready, f1_o.valid} !== tbl[c][9:8]) begin
            n_err++; $display("[TB] FAIL bp_hs c%0d: got rdy/vld %b want %b", c, {f1_i.ready, f1_o.valid}, tbl[c][9:8]);
         end
         if (tbl[c][8]) begin
            n_cmp++; if (f1_o.data !== tbl[c][7:0]) begin n_err++; $display("[TB] FAIL bp_data c%0d: got %h want %h", c, f1_o.data, tbl[c][7:0]); end
         end
         cyc();
      end
      f1_i.valid = 1'b0; f1_o.ready = 1'b0;
   endtask

   // Same row layout as the back-pressure table, applied to the skid-buffer slice.
   task automatic test_skid();
      logic [19:0] tbl [6];
      tbl = '{ {1'b1, 8'h5A, 1'b1, 1'b1, 1'b1, 8'h5A},
               {1'b1, 8'h5A, 1'b0, 1'b1, 1'b1, 8'h5A},
               {1'b1, 8'h33, 1'b0, 1'b0, 1'b1, 8'h5A},
               {1'b1, 8'h33, 1'b1, 1'b0, 1'b1, 8'h5A},
               {1'b1, 8'h33, 1'b1, 1'b1, 1'b1, 8'h33},
               {1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 8'h00} };
      for (int c = 0; c < 6; c++) begin
         bw_i.valid = tbl[c][19]; bw_i.data = tbl[c][18:11]; bw_o.ready = tbl[c][10];
         smp();
         n_cmp++; if ({bw_i.ready, bw_o.valid} !== tbl[c][9:8]) begin
            n_err++; $display("[TB] FAIL skid_hs c%0d: got rdy/vld %b want %b", c, {bw_i.ready, bw_o.valid}, tbl[c][9:8]);
         end
         if (tbl[c][8]) begin
            n_cmp++; if (bw_o.data !== tbl[c][7:0]) begin n_err++; $display("[TB] FAIL skid_data c%0d: got %h want %h", c, bw_o.data, tbl[c][7:0]); end
         end
         cyc();
      end
      bw_i.valid = 1'b0; bw_o.ready = 1'b0;
   endtask

   task automatic test_latency();
      fw3_o.ready = 1'b1; fu3_o.ready = 1'b1;
      for (int c = 0; c <= 4; c++) begin
         fw3_i.valid = (c == 0); fw3_i.data = 8'h9C;
         fu3_i.valid = (c == 0); fu3_i.data = 8'h9C;
         smp();
         n_cmp++; if ({fw3_o.valid, fu3_o.valid} !== {(c == 3), (c == 3)}) begin
            n_err++; $display("[TB] FAIL lat_valid c%0d: got fw/fu %b want %b", c, {fw3_o.valid, fu3_o.valid}, {(c == 3), (c == 3)});
         end
         if (c == 3) begin
            n_cmp++; if ({fw3_o.data, fu3_o.data} !== {8'h9C, 8'h9C}) begin
               n_err++; $display("[TB] FAIL lat_data: got %h/%h want 9c/9c", fw3_o.data, fu3_o.data);
            end
         end
         cyc();
      end
   endtask

   task automatic test_random();
      logic [7:0] fw_q[$];
      logic [7:0] fu_q[$];
      logic [7:0] fw_next = 8'h00;
      logic [7:0] fu_next = 8'h80;
      logic [7:0] exp;
      logic fw_hold = 1'b0;
      logic fu_hold = 1'b0;
      int fw_sent = 0, fw_rcvd = 0, fu_sent = 0, fu_rcvd = 0;
      for (int n = 0; n < 20000 && (fw_rcvd < 1000 || fu_rcvd < 1000); n++) begin
         fw3_i.valid = fw_hold | ((fw_sent < 1000) && ($urandom_range(0, 3) != 0));
         fw3_i.data  = fw_next;
         fw3_o.ready = ($urandom_range(0, 3) != 0);
         fu3_i.valid = fu_hold | ((fu_sent < 1000) && ($urandom_range(0, 3) != 0));
         fu3_i.data  = fu_next;
         fu3_o.ready = ($urandom_range(0, 3) != 0);
         smp();
         if (fw3_i.valid && fw3_i.ready) begin
            fw_q.push_back(fw_next); fw_next++; fw_sent++; fw_hold = 1'b0;
         end else begin
            fw_hold = fw3_i.valid;
         end
         if (fu3_i.valid && fu3_i.ready) begin
            fu_q.push_back(fu_next); fu_next++; fu_sent++; fu_hold = 1'b0;
         end else begin
            fu_hold = fu3_i.valid;
         end
         if (fw3_o.valid && fw3_o.ready) begin
            n_cmp++;
            exp = (fw_q.size() > 0) ? fw_q.pop_front() : 8'hxx;
            if (fw3_o.data !== exp) begin n_err++; $display("[TB] FAIL rand_fw3 #%0d: got %h want %h", fw_rcvd, fw3_o.data, exp); end
            fw_rcvd++;
         end
         if (fu3_o.valid && fu3_o.ready) begin
            n_cmp++;
            exp = (fu_q.size() > 0) ? fu_q.pop_front() : 8'hxx;
            if (fu3_o.data !== exp) begin n_err++; $display("[TB] FAIL rand_fu3 #%0d: got %h want %h", fu_rcvd, fu3_o.data, exp); end
            fu_rcvd++;
         end
         cyc();
      end
      n_cmp++; if (fw_rcvd != 1000 || fw_q.size() != 0) begin n_err++; $display("[TB] FAIL rand_fw3_count: got %0d want 1000", fw_rcvd); end
      n_cmp++; if (fu_rcvd != 1000 || fu_q.size() != 0) begin n_err++; $display("[TB] FAIL rand_fu3_count: got %0d want 1000", fu_rcvd); end
      fw3_i.valid = 1'b0; fu3_i.valid = 1'b0;
      fw3_o.ready = 1'b1; fu3_o.ready = 1'b1;
      cyc();
   endtask

   task automatic test_srst();
      f1_o.ready = 1'b0;
      f1_i.valid = 1'b1; f1_i.data = 8'h11;
      smp(); cyc();
      f1_i.data = 8'h22;
      smp(); cyc();
      f1_i.valid = 1'b0; srst = 1'b1;
      smp();
      n_cmp++; if ({f1_i.ready, f1_busy} !== 2'b01) begin n_err++; $display("[TB] FAIL srst_full: got rdy/busy %b want 01", {f1_i.ready, f1_busy}); end
      cyc();
      srst = 1'b0; f1_o.ready = 1'b1;
      smp();
      n_cmp++; if ({f1_o.valid, f1_busy, f1_i.ready} !== 3'b001) begin
         n_err++; $display("[TB] FAIL srst_clear: got vld/busy/rdy %b want 001", {f1_o.valid, f1_busy, f1_i.ready});
      end
      cyc();
      for (int c = 0; c < 3; c++) begin
         smp();
         n_cmp++; if (f1_o.valid !== 1'b0) begin n_err++; $display("[TB] FAIL srst_stale c%0d: got %b want 0", c, f1_o.valid); end
         cyc();
      end
   endtask

   task automatic test_async_reset();
      f1_o.ready = 1'b0; fw3_o.ready = 1'b0;
      f1_i.valid = 1'b1; f1_i.data = 8'h44; fw3_i.valid = 1'b1; fw3_i.data = 8'h66;
      smp(); cyc();
      f1_i.data = 8'h55;
      smp(); cyc();
      f1_i.valid = 1'b0; fw3_i.valid = 1'b0;
      smp();
      clk_run = 1'b0;
      #2;
      n_cmp++; if ({f1_busy, fw3_busy} !== 2'b11) begin n_err++; $display("[TB] FAIL arst_pre_busy: got %b want 11", {f1_busy, fw3_busy}); end
      aresetn = 1'b0;
      #1;
      n_cmp++; if ({f1_o.valid, f1_busy, fw3_busy} !== 3'b000) begin
         n_err++; $display("[TB] FAIL arst_clear: got vld/busy/busy %b want 000", {f1_o.valid, f1_busy, fw3_busy});
      end
      #3;
      aresetn = 1'b1;
      #2;
      f1_i.valid = 1'b1; f1_i.data = 8'h77; f1_o.ready = 1'b1; fw3_o.ready = 1'b1;
      clk_run = 1'b1;
      cyc();
      f1_i.valid = 1'b0;
      smp();
      n_cmp++; if ({f1_o.valid, f1_o.data} !== {1'b1, 8'h77}) begin
         n_err++; $display("[TB] FAIL arst_first_word: got %b/%h want 1/77", f1_o.valid, f1_o.data);
      end
      cyc();
      smp();
      n_cmp++; if (f1_o.valid !== 1'b0) begin n_err++; $display("[TB] FAIL arst_no_dup: got %b want 0", f1_o.valid); end
      cyc();
   endtask

   // Drives every scenario in order and prints the summary.
   initial begin
      f1_i.valid = 1'b0;  f1_i.data = '0;  f1_o.ready = 1'b0;
      bw_i.valid = 1'b0;  bw_i.data = '0;  bw_o.ready = 1'b0;
      fw3_i.valid = 1'b0; fw3_i.data = '0; fw3_o.ready = 1'b0;
      fu3_i.valid = 1'b0; fu3_i.data = '0; fu3_o.ready = 1'b0;
      byp_i.valid = 1'b0; byp_i.data = '0; byp_o.ready = 1'b0;
      test_reset();
      test_bypass();
      test_stream();
      test_backpressure();
      test_skid();
      test_latency();
      test_random();
      test_srst();
      test_async_reset();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
